// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one pipelined 16-bit divider among N requesters.
// A tag pipe shadows the divider so each result is routed back to the requester that issued it.
module div_share_arbiter #(
  parameter int N   = 4,
  parameter int LAT = 17
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [16*N-1:0] req_dividend,
  input  logic [16*N-1:0] req_divisor,
  output logic [N-1:0]    rsp_valid,
  input  logic [N-1:0]    rsp_ready,
  output logic [15:0]     rsp_quotient,
  output logic [15:0]     rsp_remainder,
  output logic            rsp_dz,
  output logic [15:0]     div_dividend,
  output logic [15:0]     div_divisor,
  output logic            div_stall,
  input  logic [15:0]     div_quotient,
  input  logic [15:0]     div_reminder,
  output logic [4:0]      inflight
);

  typedef struct packed {
    logic       valid;
    logic [2:0] id;
    logic       dz;
  } tag_t;

  tag_t       pipe_q [LAT];
  tag_t       head;
  tag_t       entry0_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] grant;
  logic       found;
  logic       accept;
  logic       head_ready;
  logic       leave;
  logic [4:0] inflight_q, inflight_d;

  assign head = pipe_q[LAT-1];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    head_ready = 1'b0;
    rsp_valid  = '0;
    for (int k = 0; k < N; k++) begin
      if (head.id == 3'(k)) begin
        head_ready   = rsp_ready[k];
        rsp_valid[k] = head.valid;
      end
    end
  end

  assign div_stall     = head.valid & ~head_ready;
  assign leave         = head.valid & ~div_stall;
  assign rsp_quotient  = div_quotient;
  assign rsp_remainder = div_reminder;
  assign rsp_dz        = head.dz;
  assign inflight      = inflight_q;

  // Round-robin: first requester at or above ptr, else wrap to the lowest valid one.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_valid[k] && (3'(k) >= ptr_q)) begin
        found = 1'b1;
        grant = 3'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!found && req_valid[k]) begin
        found = 1'b1;
        grant = 3'(k);
      end
    end

    accept       = found & ~div_stall & ~rst;
    req_ready    = '0;
    div_dividend = '0;
    div_divisor  = '0;
    for (int k = 0; k < N; k++) begin
      if (grant == 3'(k)) begin
        div_dividend = req_dividend[16*k +: 16];
        div_divisor  = req_divisor[16*k +: 16];
        req_ready[k] = accept;
      end
    end

    entry0_d = '0;
    ptr_d    = ptr_q;
    if (accept) begin
      entry0_d = '{valid: 1'b1, id: grant, dz: (div_divisor == 16'd0)};
      ptr_d    = (grant == 3'(N-1)) ? 3'd0 : grant + 3'd1;
    end
    inflight_d = inflight_q + {4'd0, accept} - {4'd0, leave};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the tag pipe is a handful of flops, not a RAM, so resetting every entry is cheap and
      // is what guarantees no stale response survives a mid-flight reset.
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
      ptr_q      <= '0;
      inflight_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so the shift reads pre-edge values.
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      if (!div_stall) begin
        pipe_q[0] <= entry0_d;
        for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Self-checking bench: behavioural divider, queue-based reference model, directed + random traffic.
module tb_div_share_arbiter;
  localparam int N   = 4;
  localparam int LAT = 17;
  localparam int M_FIXED = 0, M_FAIR = 1, M_RAND = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0, req_ready, rsp_valid, rsp_ready = '1;
  logic [16*N-1:0] req_dividend = '0, req_divisor = '0;
  logic [15:0]     rsp_quotient, rsp_remainder, div_dividend, div_divisor, div_quotient, div_reminder;
  logic            rsp_dz, div_stall;
  logic [4:0]      inflight;

  always #5 clk = ~clk;

  div_share_arbiter #(.N(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_dz(rsp_dz),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_stall(div_stall),
    .div_quotient(div_quotient), .div_reminder(div_reminder),
    .inflight(inflight)
  );

  // Behavioural pipelined divider (environment, never reset).
  logic [15:0] dq [LAT];
  logic [15:0] dr [LAT];
  initial for (int i = 0; i < LAT; i++) begin dq[i] = '0; dr[i] = '0; end
  always @(posedge clk) begin
    if (!div_stall) begin
      for (int i = LAT-1; i > 0; i--) begin dq[i] <= dq[i-1]; dr[i] <= dr[i-1]; end
      dq[0] <= (div_divisor == 0) ? 16'hFFFF : div_dividend / div_divisor;
      dr[0] <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
    end
  end
  assign div_quotient = dq[LAT-1];
  assign div_reminder = dr[LAT-1];

  // Reference model: issue-ordered queue of results, each aged by non-stalled edges.
  typedef struct {
    int          id;
    logic [15:0] q, r;
    bit          dz;
    int          age;
  } exp_t;
  exp_t exp_q[$];
  int   ptr_m = 0;

  // Requester drivers.
  bit          rv [N];
  logic [15:0] a [N], b [N];
  int          rem [N];
  int          mode = M_FIXED;
  logic [N-1:0] rr = '1;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, watch = 0, t_acc, t_rsp, stall_cnt, acc0, max_infl, rsp_cnt;
  logic [15:0] q_seen, r_seen;
  logic        dz_seen;
  int glog[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clr_stats(input int w);
    watch = w; t_acc = -1; t_rsp = -1; stall_cnt = 0; acc0 = 0; max_infl = 0; rsp_cnt = 0;
    q_seen = 'x; r_seen = 'x; dz_seen = 1'bx; glog.delete();
  endtask

  task automatic new_ops(input int k);
    case (mode)
      M_FAIR:  begin a[k] = 16'(k*10 + 9); b[k] = 16'd3; end
      M_RAND:  begin a[k] = 16'($urandom); b[k] = ($urandom_range(7) == 0) ? 16'd0 : 16'($urandom); end
      default: ;
    endcase
  endtask

  task automatic issue(input int k, input logic [15:0] x, input logic [15:0] y, input int n);
    rv[k] = 1'b1; a[k] = x; b[k] = y; rem[k] = n;
  endtask

  task automatic apply();
    for (int k = 0; k < N; k++) begin
      req_valid[k]             = rv[k];
      req_dividend[16*k +: 16] = a[k];
      req_divisor[16*k +: 16]  = b[k];
    end
    rsp_ready = rr;
  endtask

  // One cycle: drive at the negedge, check 1ns later, advance model at the posedge.
  task automatic step();
    bit          head_vld, exp_stall;
    int          g, hid;
    logic [N-1:0] exp_rv, exp_rdy;
    exp_t        e;
    apply();
    #1;
    head_vld  = (exp_q.size() > 0) && (exp_q[0].age == LAT);
    hid       = head_vld ? exp_q[0].id : 0;
    exp_rv    = '0;
    exp_stall = 1'b0;
    if (head_vld) begin
      exp_rv[hid] = 1'b1;
      exp_stall   = !rr[hid];
    end
    g = -1;
    if (!exp_stall)
      for (int i = 0; i < N; i++) begin
        int k;
        k = (ptr_m + i) % N;
        if (g < 0 && rv[k]) g = k;
      end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;

    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    check("div_stall", 32'(div_stall), 32'(exp_stall));
    check("inflight", 32'(inflight), 32'(exp_q.size()));
    if (head_vld) begin
      check("rsp_dz", 32'(rsp_dz), 32'(exp_q[0].dz));
      if (!exp_q[0].dz) begin
        check("rsp_quotient", 32'(rsp_quotient), 32'(exp_q[0].q));
        check("rsp_remainder", 32'(rsp_remainder), 32'(exp_q[0].r));
      end
    end

    for (int k = 0; k < N; k++) if (req_ready[k]) glog.push_back(k);
    if (req_ready[watch] && t_acc < 0) t_acc = cyc;
    if (rsp_valid[watch] && t_rsp < 0) begin
      t_rsp = cyc; q_seen = rsp_quotient; r_seen = rsp_remainder; dz_seen = rsp_dz;
    end
    if (div_stall) stall_cnt++;
    if (req_ready[0]) acc0++;
    if (rsp_valid != 0) rsp_cnt++;
    if (int'(inflight) > max_infl) max_infl = int'(inflight);

    @(posedge clk);
    if (!exp_stall) begin
      if (head_vld) void'(exp_q.pop_front());
      foreach (exp_q[i]) exp_q[i].age++;
      if (g >= 0) begin
        e.id  = g;
        e.dz  = (b[g] == 0);
        e.q   = e.dz ? 16'd0 : a[g] / b[g];
        e.r   = e.dz ? 16'd0 : a[g] % b[g];
        e.age = 1;
        exp_q.push_back(e);
        ptr_m = (g + 1) % N;
        rem[g]--;
        if (rem[g] > 0) new_ops(g); else rv[g] = 1'b0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin rv[k] = 0; a[k] = '0; b[k] = '0; rem[k] = 0; end
    apply();
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_div_stall", 32'(div_stall), 0);
    check("rst_inflight", 32'(inflight), 0);
    check("rst_rsp_dz", 32'(rsp_dz), 0);
    rst = 1'b0;

    // Fairness: all four hold valid, three ops each.
    mode = M_FAIR;
    clr_stats(0);
    for (int k = 0; k < N; k++) issue(k, 16'(k*10 + 9), 16'd3, 3);
    run(40);
    check("fair_grants", 32'(glog.size()), 12);
    for (int i = 0; i < 12 && i < glog.size(); i++) check("fair_order", 32'(glog[i]), 32'(i % N));

    // Single request 100/7.
    mode = M_FIXED;
    clr_stats(0);
    issue(0, 16'd100, 16'd7, 1);
    run(25);
    check("single_latency", 32'(t_rsp - t_acc), 32'(LAT));
    check("single_q", 32'(q_seen), 14);
    check("single_r", 32'(r_seen), 2);
    check("single_dz", 32'(dz_seen), 0);
    check("single_max_inflight", 32'(max_infl), 1);

    // Backpressure: hold req1's first result for 5 cycles while req3 keeps requesting.
    clr_stats(1);
    issue(1, 16'd1000, 16'd10, 2);
    issue(2, 16'd500, 16'd7, 2);
    issue(3, 16'd333, 16'd4, 30);
    begin
      int held = 0;
      for (int i = 0; i < 70; i++) begin
        rr = '1;
        if (held < 5 && exp_q.size() > 0 && exp_q[0].age == LAT && exp_q[0].id == 1) begin
          rr[1] = 1'b0;
          held++;
        end
        step();
      end
    end
    rr = '1;
    check("bp_stall_cycles", 32'(stall_cnt), 5);

    // Divide by zero between two normal neighbours.
    clr_stats(2);
    issue(1, 16'd50, 16'd5, 1);
    issue(2, 16'd5, 16'd0, 1);
    issue(3, 16'd77, 16'd7, 1);
    run(30);
    check("dz_flag", 32'(dz_seen), 1);
    check("dz_latency", 32'(t_rsp - t_acc), 32'(LAT));

    // Streaming: 40 back-to-back random ops from req0.
    mode = M_RAND;
    clr_stats(0);
    issue(0, 16'($urandom), 16'($urandom_range(1, 16'hFFFF)), 40);
    run(40);
    check("stream_accepts", 32'(acc0), 40);
    check("stream_max_inflight", 32'(max_infl), 32'(LAT));
    run(25);

    // Random traffic with random response backpressure.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < N; k++)
        if (!rv[k] && $urandom_range(9) == 0) begin
          rv[k] = 1'b1; rem[k] = $urandom_range(1, 5); new_ops(k);
        end
      rr = N'($urandom);
      step();
    end
    for (int k = 0; k < N; k++) rv[k] = 1'b0;
    rr = '1;
    run(30);
    check("drain_inflight", 32'(inflight), 0);

    // Reset mid-flight with ten requests outstanding and one still pending.
    mode = M_FIXED;
    issue(0, 16'd11, 16'd2, 3);
    issue(1, 16'd22, 16'd3, 3);
    issue(2, 16'd33, 16'd4, 2);
    issue(3, 16'd44, 16'd5, 3);
    run(10);
    apply();
    #3 rst = 1'b1;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    check("mid_rst_req_ready", 32'(req_ready), 0);
    check("mid_rst_inflight", 32'(inflight), 0);
    check("mid_rst_div_stall", 32'(div_stall), 0);
    exp_q.delete();
    ptr_m = 0;
    for (int k = 0; k < N; k++) rv[k] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clr_stats(2);
    issue(2, 16'd200, 16'd9, 1);
    run(30);
    check("post_rst_latency", 32'(t_rsp - t_acc), 32'(LAT));
    check("post_rst_q", 32'(q_seen), 22);
    check("post_rst_r", 32'(r_seen), 2);
    check("post_rst_rsp_count", 32'(rsp_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_share_arbiter.md
# div_share_arbiter

Shares one 16-bit, 17-stage pipelined divider among N requesters. Each requester issues dividend/divisor pairs over a valid/ready handshake. The block arbitrates round-robin, drives the divider inputs and its `stall`, and carries a requester tag through a shadow pipeline matched to the divider latency. Results are routed back with per-requester response handshakes, and response backpressure freezes the divider.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `LAT`, default 17: divider latency in cycles, from the accept edge to the first cycle its quotient/remainder are valid.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `req_valid`  in  N: request valid per requester.
- `req_ready`  out  N: request accepted per requester; one-hot or zero.
- `req_dividend`  in  16*N: dividend; requester k uses bits [16k+15:16k].
- `req_divisor`  in  16*N: divisor; same packing as `req_dividend`.
- `rsp_valid`  out  N: result available for requester k; one-hot or zero.
- `rsp_ready`  in  N: requester k accepts its result.
- `rsp_quotient`  out  16: quotient, shared bus.
- `rsp_remainder`  out  16: remainder, shared bus.
- `rsp_dz`  out  1: result came from divisor == 0.
- `div_dividend`  out  16: divider input.
- `div_divisor`  out  16: divider input.
- `div_stall`  out  1: freezes the divider pipeline.
- `div_quotient`  in  16: divider output.
- `div_reminder`  in  16: divider output.
- `inflight`  out  5: number of valid tag-pipe entries, range 0..LAT.

## Operation
- Tag pipe: LAT entries, each {valid, id[2:0], dz}. It shifts on every edge with `div_stall`=0 and holds when `div_stall`=1, in lockstep with the divider.
- Head entry = entry LAT-1.
- `div_stall` = head.valid & ~rsp_ready[head.id]. This path is combinational from `rsp_ready`.
- `rsp_valid[k]` = head.valid & (head.id==k).
- `rsp_quotient`/`rsp_remainder` = `div_quotient`/`div_reminder`, passed straight through.
- `rsp_dz` = head.dz.
- Issue path:
  - Arbitration is evaluated only when `div_stall`=0.
  - Grant = first k with `req_valid[k]`, searching ptr, ptr+1, …, mod N.
  - `req_ready[grant]`=1. All `req_ready` are 0 when `div_stall`=1 or no request is pending.
  - `div_dividend`/`div_divisor` = granted requester's operands, muxed combinationally. They are don't-care when there is no grant.
- On an accept edge:
  - Entry 0 <= {1, grant, divisor==0}.
  - ptr <= grant+1 mod N.
- On a non-stalled edge with no accept, entry 0 <= {0, x, x}, i.e. a bubble. ptr is unchanged.
- Response completes on `rsp_valid[k]` & `rsp_ready[k]`. On that edge the head entry shifts out normally, because no stall is raised.
- `inflight` bookkeeping:
  - +1 on accept.
  - −1 on a valid entry leaving the head (response handshake).
  - Both on the same edge: unchanged.
  - Never exceeds LAT.
- Divide by zero: the request is still issued. The quotient/remainder values are whatever the divider produces and are unspecified; `rsp_dz`=1 flags the result.
- Results return in issue order. There is no per-requester reordering.

## Timing
- Reset values: all tag valid bits 0, ptr 0, `inflight` 0. Consequently `req_ready` = 0, `rsp_valid` = 0, `rsp_dz` = 0, `div_stall` = 0.
- Reset asserted mid-operation: all in-flight requests are discarded and no responses are issued for them. Divider contents are ignored because their tags are invalid.
- Latency: a request accepted on edge E gives `rsp_valid` high in the cycle after edge E+LAT−1, i.e. LAT cycles later with no stalls. Each stall cycle adds exactly one cycle.
- Throughput: one accept per cycle while `div_stall`=0.
- Simultaneous accept and response on the same edge is legal, including for the same requester.
- A requester holding `req_valid` with changing operands before the accept is a protocol violation; the bench need not check it.

## Test plan
- Single request: req0 with 100/7, `rsp_ready`=all 1 → `rsp_valid[0]` exactly 17 cycles after accept, q=14, r=2, `rsp_dz`=0. `inflight` goes 1 then back to 0.
- Fairness: all 4 requesters hold valid from cycle 0 with k*10+9 / 3 → grants 0,1,2,3,0,… on consecutive cycles. Responses arrive in the same order, each with the correct q/r.
- Backpressure: result for req1 at head, `rsp_ready[1]` low for 5 cycles → `div_stall` high 5 cycles, no `req_ready`, outputs stable. After release, the remaining results arrive 5 cycles late and uncorrupted.
- Divide by zero: req2 with 5/0 → `rsp_valid[2]` after 17 cycles with `rsp_dz`=1. Neighbouring results are unaffected.
- Streaming: req0 issues 40 back-to-back ops with random operands → 1 accept per cycle. `inflight` saturates at 17. All 40 results match the reference model, in order.
- Reset mid-flight: 10 requests in flight, `rst` pulsed asynchronously mid-cycle → outputs go to reset values immediately. No stale `rsp_valid` appears afterwards. A new request is then handled with normal 17-cycle latency.
